// File: rtl/dmem_axil_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_axil_pkg
// Description : Shared types and constants for the AXI4-Lite to data-memory
//               port-B bridge: controller state encoding and AXI response
//               codes.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_axil_pkg;

    // Controller states; explicit 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WRITE    = 3'd1,
        WRESP    = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        RRESP    = 3'd5
    } dmem_axil_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

endpackage
`default_nettype wire

// File: rtl/dmem_axil_port_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_axil_port_if
// Description : AXI4-Lite channel bundle between the PS interconnect
//               (master) and the data-memory port-B bridge (slave).
//   AW : s_awaddr, s_awvalid, s_awready
//   W  : s_wdata, s_wstrb, s_wvalid, s_wready
//   B  : s_bresp, s_bvalid, s_bready
//   AR : s_araddr, s_arvalid, s_arready
//   R  : s_rdata, s_rresp, s_rvalid, s_rready
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_axil_port_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int WIDTH          = 32,
    parameter int NUM_COL        = 4
);
    logic [AXI_ADDR_WIDTH-1:0] s_awaddr;
    logic                      s_awvalid;
    logic                      s_awready;
    logic [WIDTH-1:0]          s_wdata;
    logic [NUM_COL-1:0]        s_wstrb;
    logic                      s_wvalid;
    logic                      s_wready;
    logic [1:0]                s_bresp;
    logic                      s_bvalid;
    logic                      s_bready;
    logic [AXI_ADDR_WIDTH-1:0] s_araddr;
    logic                      s_arvalid;
    logic                      s_arready;
    logic [WIDTH-1:0]          s_rdata;
    logic [1:0]                s_rresp;
    logic                      s_rvalid;
    logic                      s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

endinterface
`default_nettype wire

// File: rtl/dmem_axil_port.sv
`default_nettype none
// ============================================================================
// Module      : dmem_axil_port
// Description : AXI4-Lite slave giving the PS single-cycle access to data
//               memory port B. One transaction in flight; a write uses one
//               memory cycle, a read waits out the one-cycle synchronous
//               read latency before returning data.
// Ports       :
//   clk, reset       - clock, synchronous active-high reset
//   s_axil           - AXI4-Lite slave channels (dmem_axil_port_if.slave)
//   dmem_data_in     - write data to data_in_B
//   dmem_data_out    - read data from data_out_B (valid one cycle after addr)
//   dmem_word_addr   - byte address, bits [1:0] zero, to word_addr_B
//   dmem_byte_wr_en  - byte write enables to byte_wr_en_B
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_axil_port
    import dmem_axil_pkg::*;
#(
    parameter int SIZE           = 256,
    parameter int WIDTH          = 32,
    parameter int NUM_COL        = 4,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    dmem_axil_port_if.slave           s_axil,
    output logic [WIDTH-1:0]          dmem_data_in,
    input  logic [WIDTH-1:0]          dmem_data_out,
    output logic [$clog2(SIZE)+1:0]   dmem_word_addr,
    output logic [NUM_COL-1:0]        dmem_byte_wr_en
);

    localparam int LOGSIZE = $clog2(SIZE);
    localparam int WA_W    = LOGSIZE + 2;

    dmem_axil_state_t    r_state;
    dmem_axil_state_t    w_state_next;

    logic                r_prio;       // 0: write wins a tie, 1: read wins
    logic                r_oor;        // latched out-of-range flag
    logic [WA_W-1:0]     r_word_addr;
    logic [WIDTH-1:0]    r_wdata;
    logic [NUM_COL-1:0]  r_wstrb;
    logic [WIDTH-1:0]    r_rdata;
    logic [1:0]          r_bresp;
    logic [1:0]          r_rresp;

    logic                w_idle;
    logic                w_wr_req;
    logic                w_rd_req;
    logic                w_both;
    logic                w_grant_wr;
    logic                w_grant_rd;
    logic                w_wr_oor;
    logic                w_rd_oor;

    // Any address bit above the memory's byte range marks the access invalid.
    function automatic logic out_of_range(input logic [AXI_ADDR_WIDTH-1:0] a);
        return (a >> WA_W) != '0;
    endfunction

    assign w_wr_oor = out_of_range(s_axil.s_awaddr);
    assign w_rd_oor = out_of_range(s_axil.s_araddr);

    // A write needs both AW and W present so the two channels are
    // accepted together and the memory write can be issued as one beat.
    assign w_idle     = (r_state == IDLE) && !reset;
    assign w_wr_req   = s_axil.s_awvalid && s_axil.s_wvalid;
    assign w_rd_req   = s_axil.s_arvalid;
    assign w_both     = w_idle && w_wr_req && w_rd_req;
    assign w_grant_wr = w_idle && w_wr_req && (!w_rd_req || !r_prio);
    assign w_grant_rd = w_idle && w_rd_req && (!w_wr_req ||  r_prio);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_wr) begin
                    w_state_next = WRITE;
                end else if (w_grant_rd) begin
                    w_state_next = RD_ISSUE;
                end
            end
            WRITE:    w_state_next = WRESP;
            WRESP:    if (s_axil.s_bready) w_state_next = IDLE;
            RD_ISSUE: w_state_next = RD_WAIT;
            RD_WAIT:  w_state_next = RRESP;
            RRESP:    if (s_axil.s_rready) w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // Enables and valids are masked by reset so an abandoned transaction
    // neither writes memory nor completes a response handshake.
    always_comb begin
        s_axil.s_awready = 1'b0;
        s_axil.s_wready  = 1'b0;
        s_axil.s_arready = 1'b0;
        s_axil.s_bvalid  = 1'b0;
        s_axil.s_rvalid  = 1'b0;
        dmem_byte_wr_en  = '0;
        case (r_state)
            IDLE: begin
                s_axil.s_awready = w_grant_wr;
                s_axil.s_wready  = w_grant_wr;
                s_axil.s_arready = w_grant_rd;
            end
            WRITE:   dmem_byte_wr_en = (r_oor || reset) ? '0 : r_wstrb;
            WRESP:   s_axil.s_bvalid = !reset;
            RRESP:   s_axil.s_rvalid = !reset;
            default: ;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prio      <= 1'b0;
            r_oor       <= 1'b0;
            r_word_addr <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rdata     <= '0;
            r_bresp     <= AXI_RESP_OKAY;
            r_rresp     <= AXI_RESP_OKAY;
        end else begin
            if (w_both) begin
                r_prio <= ~r_prio;
            end
            if (w_grant_wr) begin
                r_word_addr <= {s_axil.s_awaddr[WA_W-1:2], 2'b00};
                r_wdata     <= s_axil.s_wdata;
                r_wstrb     <= s_axil.s_wstrb;
                r_oor       <= w_wr_oor;
                r_bresp     <= w_wr_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end else if (w_grant_rd) begin
                r_word_addr <= {s_axil.s_araddr[WA_W-1:2], 2'b00};
                r_oor       <= w_rd_oor;
            end
            // Memory output is valid here, one cycle after RD_ISSUE.
            if (r_state == RD_WAIT) begin
                r_rdata <= r_oor ? '0 : dmem_data_out;
                r_rresp <= r_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            end
        end
    end

    assign s_axil.s_bresp = r_bresp;
    assign s_axil.s_rresp = r_rresp;
    assign s_axil.s_rdata = r_rdata;
    assign dmem_word_addr = r_word_addr;
    assign dmem_data_in   = r_wdata;

endmodule
`default_nettype wire
